// File: rtl/camera_pkg.sv
// Shared camera types and default exposure limits, used by exposure_timer,
// the top level and the FSM_ex_control bench.
package camera_pkg;

  localparam int unsigned EXP_W           = 5;
  localparam int unsigned DEF_EXP_MIN     = 2;
  localparam int unsigned DEF_EXP_MAX     = 30;
  localparam int unsigned DEF_EXP_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE,
    EXPOSE,
    READ
  } exp_state_t;

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector: one-cycle pulse the edge after btn rises.
// History is cleared by reset, so a button held through reset fires once.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= btn;
      pulse <= btn & ~prev;
    end
  end

endmodule

// File: rtl/exposure_timer.sv
// Exposure setting register plus exposure/readout phase timers that feed
// Ovf5/Ovf4 back to the exposure-control FSM.
module exposure_timer
  import camera_pkg::*;
#(
  parameter int unsigned EXP_MIN        = DEF_EXP_MIN,
  parameter int unsigned EXP_MAX        = DEF_EXP_MAX,
  parameter int unsigned EXP_DEFAULT    = DEF_EXP_DEFAULT,
  parameter int unsigned TICKS_PER_UNIT = 1000,
  parameter int unsigned READ_CYCLES    = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  input  logic             Start_exp,
  input  logic             Start_read,
  output logic             Ovf5,
  output logic             Ovf4,
  output logic [EXP_W-1:0] Exp_time,
  output logic             Busy
);

  localparam int unsigned PRE_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int unsigned RD_W  = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_UNIT - 1);
  localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(READ_CYCLES - 1);
  localparam logic [EXP_W-1:0] LIM_MIN  = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] LIM_MAX  = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] LIM_DEF  = EXP_W'(EXP_DEFAULT);

  exp_state_t       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic [EXP_W-1:0] unit_q, unit_d;
  logic [EXP_W-1:0] exp_d;
  logic             ovf5_d, ovf4_d;
  logic             inc_p, dec_p;

  btn_edge u_inc_edge (
    .clk   (Clk),
    .reset (Reset),
    .btn   (Exp_increase),
    .pulse (inc_p)
  );

  btn_edge u_dec_edge (
    .clk   (Clk),
    .reset (Reset),
    .btn   (Exp_decrease),
    .pulse (dec_p)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      rd_q     <= '0;
      unit_q   <= '0;
      Exp_time <= LIM_DEF;
      Ovf5     <= 1'b0;
      Ovf4     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      rd_q     <= rd_d;
      unit_q   <= unit_d;
      Exp_time <= exp_d;
      Ovf5     <= ovf5_d;
      Ovf4     <= ovf4_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rd_d    = rd_q;
    unit_d  = unit_q;
    exp_d   = Exp_time;
    ovf5_d  = 1'b0;
    ovf4_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Button edges only adjust the setting here; elsewhere they are dropped.
        if (inc_p && !dec_p && (Exp_time < LIM_MAX)) begin
          exp_d = Exp_time + 1'b1;
        end else if (dec_p && !inc_p && (Exp_time > LIM_MIN)) begin
          exp_d = Exp_time - 1'b1;
        end
        if (Start_exp) begin
          state_d = EXPOSE;
          unit_d  = Exp_time;
          pre_d   = '0;
        end else if (Start_read) begin
          state_d = READ;
          rd_d    = '0;
        end
      end
      EXPOSE: begin
        if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          unit_d = unit_q - 1'b1;
          if (unit_q == EXP_W'(1)) begin
            ovf5_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      READ: begin
        if (rd_q == RD_LAST) begin
          ovf4_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rd_d = rd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_exposure_timer.sv
// Directed bench for exposure_timer with TICKS_PER_UNIT=4, READ_CYCLES=4.
module tb_exposure_timer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Exp_increase;
  logic       Exp_decrease;
  logic       Start_exp;
  logic       Start_read;
  logic       Ovf5;
  logic       Ovf4;
  logic [4:0] Exp_time;
  logic       Busy;

  int checks   = 0;
  int failures = 0;
  int exp_model;

  exposure_timer #(
    .EXP_MIN        (2),
    .EXP_MAX        (30),
    .EXP_DEFAULT    (15),
    .TICKS_PER_UNIT (4),
    .READ_CYCLES    (4)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Exp_increase (Exp_increase),
    .Exp_decrease (Exp_decrease),
    .Start_exp    (Start_exp),
    .Start_read   (Start_read),
    .Ovf5         (Ovf5),
    .Ovf4         (Ovf4),
    .Exp_time     (Exp_time),
    .Busy         (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic press_inc();
    Exp_increase = 1'b1;
    tick();
    Exp_increase = 1'b0;
    tick();
    tick();
  endtask

  task automatic press_dec();
    Exp_decrease = 1'b1;
    tick();
    Exp_decrease = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    Reset        = 1'b1;
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    Start_exp    = 1'b0;
    Start_read   = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check("rst_exp_time", Exp_time, 15);
    check("rst_busy", Busy, 0);
    check("rst_ovf5", Ovf5, 0);
    check("rst_ovf4", Ovf4, 0);

    // Saturating setting adjustment
    exp_model = 15;
    for (int i = 0; i < 20; i++) begin
      press_inc();
      exp_model = (exp_model < 30) ? exp_model + 1 : 30;
      check("inc_sat", Exp_time, exp_model);
    end
    for (int i = 0; i < 40; i++) begin
      press_dec();
      exp_model = (exp_model > 2) ? exp_model - 1 : 2;
      check("dec_sat", Exp_time, exp_model);
    end
    press_inc();
    check("set_three", Exp_time, 3);

    // Exposure of 3 units = 12 cycles
    Start_exp = 1'b1;
    tick();
    Start_exp = 1'b0;
    check("exp_busy_rise", Busy, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("exp_ovf5", Ovf5, (k == 12) ? 1 : 0);
      check("exp_busy", Busy, (k == 12) ? 0 : 1);
    end
    tick();
    check("exp_ovf5_width", Ovf5, 0);

    // Readout of 4 cycles
    Start_read = 1'b1;
    tick();
    Start_read = 1'b0;
    check("rd_busy_rise", Busy, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rd_ovf4", Ovf4, (k == 4) ? 1 : 0);
      check("rd_busy", Busy, (k == 4) ? 0 : 1);
    end
    tick();
    check("rd_ovf4_width", Ovf4, 0);

    // Simultaneous starts: exposure wins
    Start_exp  = 1'b1;
    Start_read = 1'b1;
    tick();
    Start_exp  = 1'b0;
    Start_read = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("both_ovf4", Ovf4, 0);
      check("both_ovf5", Ovf5, (k == 12) ? 1 : 0);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      check("both_no_read", Ovf4 | Busy, 0);
    end

    // Button edges and Start_read during EXPOSE are discarded
    Start_exp = 1'b1;
    tick();
    Start_exp = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("busy_ovf5", Ovf5, (k == 12) ? 1 : 0);
      check("busy_exp_frozen", Exp_time, 3);
      Exp_increase = (k == 2) || (k == 6);
      Start_read   = (k == 5);
    end
    Exp_increase = 1'b0;
    Start_read   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("after_busy_idle", Busy | Ovf4, 0);
    end
    check("after_busy_exp", Exp_time, 3);

    // Inc and dec edges in the same cycle cancel
    Exp_increase = 1'b1;
    Exp_decrease = 1'b1;
    tick();
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    tick();
    tick();
    check("inc_dec_same", Exp_time, 3);

    // Back-to-back exposure: start accepted in the Ovf5 cycle
    Start_exp = 1'b1;
    tick();
    Start_exp = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("b2b_first_ovf5", Ovf5, (k == 12) ? 1 : 0);
    end
    Start_exp = 1'b1;
    tick();
    Start_exp = 1'b0;
    check("b2b_busy", Busy, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("b2b_second_ovf5", Ovf5, (k == 12) ? 1 : 0);
    end

    // Reset in the middle of an exposure
    Start_exp = 1'b1;
    tick();
    Start_exp = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    check("mid_busy_before", Busy, 1);
    Reset = 1'b1;
    tick();
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_exp", Exp_time, 15);
    check("mid_rst_ovf5", Ovf5, 0);
    Reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("mid_rst_no_ovf5", Ovf5 | Busy, 0);
    end

    // Button held through reset registers one edge on release
    Exp_increase = 1'b1;
    Reset        = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    tick();
    tick();
    check("held_through_rst", Exp_time, 16);
    Exp_increase = 1'b0;
    tick();
    tick();
    check("held_release", Exp_time, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
